// File: rtl/idex_pkg.sv
// Shared constants and types for the ID/EX pipeline register.
package idex_pkg;

  localparam int unsigned IDEX_DATA_W  = 16;
  localparam int unsigned IDEX_REG_AW  = 4;
  localparam int unsigned IDEX_ALUOP_W = 4;
  localparam int unsigned CTRL_W       = 4;

  localparam int unsigned CTRL_REGWRITE = 3;
  localparam int unsigned CTRL_MEMTOREG = 2;
  localparam int unsigned CTRL_MEMREAD  = 1;
  localparam int unsigned CTRL_MEMWRITE = 0;

  typedef enum logic [1:0] {
    StEmpty,
    StOne,
    StTwo
  } idex_state_e;

endpackage

// File: rtl/idex_slot.sv
// One pipeline slot: valid flag plus payload register. Clear drops only the
// valid flag so the payload keeps its last value.
module idex_slot #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [Width-1:0] d_i,
  output logic             valid_o,
  output logic [Width-1:0] q_o
);

  logic             valid_q;
  logic [Width-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= d_i;
    end
  end

  assign valid_o = valid_q;
  assign q_o     = data_q;

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with a two-entry skid buffer so in_ready_o is a flop.
// Optional stall/bubble counters are built when IDEX_PERF_EN is defined.
module id_ex_pipe
  import idex_pkg::*;
#(
  parameter int unsigned DATA_W  = IDEX_DATA_W,
  parameter int unsigned REG_AW  = IDEX_REG_AW,
  parameter int unsigned ALUOP_W = IDEX_ALUOP_W
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [CTRL_W-1:0]   ctrl_i,
  input  logic [ALUOP_W-1:0]  aluop_i,
  input  logic [2*DATA_W-1:0] src_i,
  input  logic [DATA_W-1:0]   memdata_i,
  input  logic [4*REG_AW-1:0] regs_i,
  input  logic [DATA_W-1:0]   epc_i,
  input  logic                flush_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [CTRL_W-1:0]   ctrl_o,
  output logic [ALUOP_W-1:0]  aluop_o,
  output logic [2*DATA_W-1:0] src_o,
  output logic [DATA_W-1:0]   memdata_o,
  output logic [4*REG_AW-1:0] regs_o,
  output logic [DATA_W-1:0]   epc_o
`ifdef IDEX_PERF_EN
  ,
  output logic [15:0]         bubble_cnt_o,
  output logic [15:0]         stall_cnt_o
`endif
);

  localparam int unsigned PW = CTRL_W + ALUOP_W + 4 * DATA_W + 4 * REG_AW;

  logic [PW-1:0]     in_pl, main_d, main_q, skid_q;
  logic              main_valid, skid_valid;
  logic              main_load, main_clr, main_sel_skid, skid_load, skid_clr;
  logic [CTRL_W-1:0] ctrl_q;
  idex_state_e       state;

  assign in_pl  = {ctrl_i, aluop_i, src_i, memdata_i, regs_i, epc_i};
  assign main_d = main_sel_skid ? skid_q : in_pl;

  always_comb begin
    main_load     = 1'b0;
    main_clr      = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clr      = 1'b0;
    if (skid_valid)      state = StTwo;
    else if (main_valid) state = StOne;
    else                 state = StEmpty;

    if (flush_i) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state)
        StEmpty: main_load = in_valid_i;
        StOne: begin
          if (out_ready_i) begin
            main_load = in_valid_i;
            main_clr  = !in_valid_i;
          end else begin
            skid_load = in_valid_i;
          end
        end
        // in_ready_o is low here, so no new beat can arrive this cycle.
        StTwo: begin
          if (out_ready_i) begin
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
            skid_clr      = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  idex_slot #(.Width(PW)) u_main (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clr_i   (main_clr),
    .load_i  (main_load),
    .d_i     (main_d),
    .valid_o (main_valid),
    .q_o     (main_q)
  );

  idex_slot #(.Width(PW)) u_skid (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clr_i   (skid_clr),
    .load_i  (skid_load),
    .d_i     (in_pl),
    .valid_o (skid_valid),
    .q_o     (skid_q)
  );

  assign {ctrl_q, aluop_o, src_o, memdata_o, regs_o, epc_o} = main_q;
  assign ctrl_o      = main_valid ? ctrl_q : '0;
  assign out_valid_o = main_valid;
  assign in_ready_o  = !skid_valid;

`ifdef IDEX_PERF_EN
  logic [15:0] bubble_q, stall_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      bubble_q <= '0;
      stall_q  <= '0;
    end else begin
      if (!main_valid && bubble_q != 16'hFFFF) bubble_q <= bubble_q + 16'd1;
      if (main_valid && !out_ready_i && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

  assign bubble_cnt_o = bubble_q;
  assign stall_cnt_o  = stall_q;
`endif

endmodule
